// File: rtl/axi3_mst.sv
// AXI3 burst master: turns word-count commands into INCR bursts split at 4 KB and MAX_BEATS.
// Optional stall watchdog enabled with `define AXI3_MST_TIMEOUT_EN.
module axi3_mst #(
    parameter logic [3:0] AXI_ID    = 4'h1,
    parameter int         MAX_BEATS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_len,
    output logic        done,
    output logic        resp_err,
    output logic        to_err,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, NEXT, DONE} state_t;

    state_t      state;
    logic        is_write;
    logic [31:0] addr_q;
    logic [15:0] rem_q;
    logic [4:0]  beats_q;
    logic [4:0]  beat_cnt;
    logic [31:0] ax_addr;
    logic [3:0]  ax_len;

    logic        accept, issue, iss_write;
    logic [31:0] iss_addr;
    logic [15:0] iss_rem;
    logic [4:0]  iss_beats;
    logic        wr_phase, rd_phase;
    logic        aw_hs, ar_hs, w_hs, r_hs, b_hs;

    // Beats limited by MAX_BEATS, words left, and words up to the next 4 KB page.
    function automatic logic [4:0] calc_beats(input logic [9:0] word_off, input logic [15:0] rem);
        logic [15:0] beats;
        logic [15:0] to_4k;
        to_4k = 16'd1024 - {6'd0, word_off};
        beats = 16'(MAX_BEATS);
        if (to_4k < beats) beats = to_4k;
        if (rem < beats) beats = rem;
        return 5'(beats);
    endfunction

    always_comb begin
        if (state == IDLE) begin
            iss_addr  = cmd_addr & 32'hFFFF_FFFC;
            iss_rem   = cmd_len;
            iss_write = cmd_write;
        end else begin
            iss_addr  = addr_q;
            iss_rem   = rem_q;
            iss_write = is_write;
        end
        iss_beats = calc_beats(iss_addr[11:2], iss_rem);
    end

    assign accept = (state == IDLE) && cmd_valid;
    assign issue  = (accept && (cmd_len != 16'd0)) || ((state == NEXT) && (rem_q != 16'd0));

    assign cmd_ready = (state == IDLE);
    assign wr_phase  = (state == DATA) && is_write;
    assign rd_phase  = (state == DATA) && !is_write;

    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign arid    = AXI_ID;
    assign awaddr  = ax_addr;
    assign araddr  = ax_addr;
    assign awlen   = ax_len;
    assign arlen   = ax_len;
    assign awsize  = 3'b010;
    assign arsize  = 3'b010;
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign awlock  = 2'b00;
    assign arlock  = 2'b00;
    assign wstrb   = 4'hF;

    // Data channels are pass-through while a burst is in its data phase.
    assign wvalid   = wr_phase & wr_valid;
    assign wr_ready = wr_phase & wready;
    assign wdata    = wr_phase ? wr_data : 32'd0;
    assign wlast    = wr_phase && (beat_cnt == beats_q - 5'd1);
    assign rd_valid = rd_phase & rvalid;
    assign rready   = rd_phase & rd_ready;
    assign rd_data  = rd_phase ? rdata : 32'd0;

    assign aw_hs = awvalid & awready;
    assign ar_hs = arvalid & arready;
    assign w_hs  = wvalid & wready;
    assign r_hs  = rvalid & rready;
    assign b_hs  = bvalid & bready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            is_write <= 1'b0;
            addr_q   <= 32'd0;
            rem_q    <= 16'd0;
            beats_q  <= 5'd0;
            beat_cnt <= 5'd0;
            ax_addr  <= 32'd0;
            ax_len   <= 4'd0;
            awvalid  <= 1'b0;
            arvalid  <= 1'b0;
            bready   <= 1'b0;
            done     <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        resp_err <= 1'b0;
                        is_write <= cmd_write;
                        if (cmd_len == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (aw_hs || ar_hs) begin
                        awvalid  <= 1'b0;
                        arvalid  <= 1'b0;
                        beat_cnt <= 5'd0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 5'd1;
                        if (wlast) begin
                            bready <= 1'b1;
                            state  <= RESP;
                        end
                    end else if (r_hs) begin
                        beat_cnt <= beat_cnt + 5'd1;
                        if (rlast) state <= NEXT;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        bready <= 1'b0;
                        state  <= NEXT;
                    end
                end
                NEXT: begin
                    if (rem_q == 16'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (issue) begin
                ax_addr <= iss_addr;
                ax_len  <= 4'(iss_beats - 5'd1);
                beats_q <= iss_beats;
                addr_q  <= iss_addr + {25'd0, iss_beats, 2'b00};
                rem_q   <= iss_rem - {11'd0, iss_beats};
                awvalid <= iss_write;
                arvalid <= !iss_write;
                state   <= ADDR;
            end

            // Errors are recorded but never stop the transfer.
            if (r_hs && ((rresp != 2'b00) || (rid != AXI_ID))) resp_err <= 1'b1;
            if (b_hs && ((bresp != 2'b00) || (bid != AXI_ID))) resp_err <= 1'b1;
        end
    end

`ifdef AXI3_MST_TIMEOUT_EN
    logic [9:0] to_cnt;
    logic       stall, any_hs;

    assign stall  = (awvalid & !awready) | (arvalid & !arready) | (wvalid & !wready);
    assign any_hs = aw_hs | ar_hs | w_hs | r_hs | b_hs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= 10'd0;
            to_err <= 1'b0;
        end else begin
            if (any_hs) to_cnt <= 10'd0;
            else if (stall && (to_cnt != 10'h3FF)) to_cnt <= to_cnt + 10'd1;
            if (accept) to_err <= 1'b0;
            else if (to_cnt == 10'h3FF) to_err <= 1'b1;
        end
    end
`else
    assign to_err = 1'b0;
`endif

endmodule
